// File: rtl/sdram_burst_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// sdram_burst_scheduler_pkg : state/grant encodings and parameter sanity check
// Revision: 1.0
// ============================================================================
package sdram_burst_scheduler_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_WR_REQ   = 3'd1,
      ST_WR_BURST = 3'd2,
      ST_RD_REQ   = 3'd3,
      ST_RD_BURST = 3'd4
   } sched_state_t;

   typedef enum logic {
      GRANT_WR = 1'b0,
      GRANT_RD = 1'b1
   } grant_t;

   function automatic bit params_ok(input int addr_w, input int fifo_w, input int burst_len,
                                    input int frame_words, input int rd_thresh);
      if (burst_len < 1 || (burst_len & (burst_len - 1)) != 0) return 1'b0;
      if (longint'(burst_len) > (longint'(1) << fifo_w)) return 1'b0;
      if (frame_words < burst_len || (frame_words % burst_len) != 0) return 1'b0;
      if (longint'(frame_words) >= (longint'(1) << addr_w)) return 1'b0;
      if (rd_thresh < 1 || longint'(rd_thresh) > (longint'(1) << fifo_w)) return 1'b0;
      return 1'b1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sdram_burst_scheduler_frame_addr_ctr.sv
`default_nettype none
// ============================================================================
// frame_addr_ctr : per-path burst address counter with frame-end flag and deferred load
// Revision: 1.0
// ============================================================================
module frame_addr_ctr #(
   parameter int ADDR_W      = 20,
   parameter int BURST_LEN   = 256,
   parameter int FRAME_WORDS = 307200
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              step,
   input  logic              busy_own,
   output logic [ADDR_W-1:0] addr,
   output logic              frame_done
);

   localparam logic [ADDR_W-1:0] c_step      = ADDR_W'(BURST_LEN);
   localparam logic [ADDR_W-1:0] c_frame_end = ADDR_W'(FRAME_WORDS);

   logic              r_pending;
   logic [ADDR_W-1:0] w_next_addr;

   assign w_next_addr = addr + c_step;

   // A load that lands while this path owns the bus is deferred to the burst's completion.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr       <= '0;
         frame_done <= 1'b0;
         r_pending  <= 1'b0;
      end else if (load && (!busy_own || step)) begin
         addr       <= '0;
         frame_done <= 1'b0;
         r_pending  <= 1'b0;
      end else if (load) begin
         r_pending  <= 1'b1;
      end else if (step) begin
         if (r_pending) begin
            addr       <= '0;
            frame_done <= 1'b0;
            r_pending  <= 1'b0;
         end else if (w_next_addr == c_frame_end) begin
            addr       <= '0;
            frame_done <= 1'b1;
         end else begin
            addr       <= w_next_addr;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/sdram_burst_scheduler.sv
`default_nettype none
// ============================================================================
// sdram_burst_scheduler : round-robin SDRAM burst arbiter for camera writes / VGA reads
// Revision: 1.0
// ============================================================================
module sdram_burst_scheduler
   import sdram_burst_scheduler_pkg::*;
#(
   parameter int ADDR_W      = 20,
   parameter int FIFO_W      = 10,
   parameter int BURST_LEN   = 256,
   parameter int FRAME_WORDS = 307200,
   parameter int RD_THRESH   = 512
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_load,
   input  logic              rd_load,
   input  logic [1:0]        wr_bank,
   input  logic [1:0]        rd_bank,
   input  logic [FIFO_W-1:0] wrf_usedw,
   input  logic [FIFO_W-1:0] rdf_usedw,
   input  logic              rd_enable,
   input  logic              sd_ack,
   input  logic              sd_done,
   output logic              sd_wr_req,
   output logic              sd_rd_req,
   output logic [ADDR_W+1:0] sd_addr,
   output logic              frame_write_done,
   output logic              frame_read_done,
   output logic              busy
);

   generate
      if (!params_ok(ADDR_W, FIFO_W, BURST_LEN, FRAME_WORDS, RD_THRESH)) begin : g_bad_params
         $fatal(1, "sdram_burst_scheduler: illegal parameter combination");
      end
   endgenerate

   localparam logic [FIFO_W:0] c_burst_len = (FIFO_W+1)'(BURST_LEN);
   localparam logic [FIFO_W:0] c_rd_thresh = (FIFO_W+1)'(RD_THRESH);

   sched_state_t      r_state;
   grant_t            r_last_grant;
   logic [ADDR_W-1:0] w_wr_addr;
   logic [ADDR_W-1:0] w_rd_addr;
   logic [ADDR_W-1:0] w_wr_start;
   logic [ADDR_W-1:0] w_rd_start;
   logic              w_wr_elig;
   logic              w_rd_elig;
   logic              w_wr_own;
   logic              w_rd_own;
   logic              w_wr_step;
   logic              w_rd_step;

   assign w_wr_elig = ({1'b0, wrf_usedw} >= c_burst_len) && !frame_write_done;
   assign w_rd_elig = rd_enable && ({1'b0, rdf_usedw} < c_rd_thresh) && !frame_read_done;

   assign w_wr_own  = (r_state == ST_WR_REQ) || (r_state == ST_WR_BURST);
   assign w_rd_own  = (r_state == ST_RD_REQ) || (r_state == ST_RD_BURST);
   assign w_wr_step = ((r_state == ST_WR_REQ) && sd_ack && sd_done) ||
                      ((r_state == ST_WR_BURST) && sd_done);
   assign w_rd_step = ((r_state == ST_RD_REQ) && sd_ack && sd_done) ||
                      ((r_state == ST_RD_BURST) && sd_done);

   // A load in the deciding cycle restarts the frame, so the latched address must already be 0.
   assign w_wr_start = wr_load ? '0 : w_wr_addr;
   assign w_rd_start = rd_load ? '0 : w_rd_addr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_last_grant <= GRANT_WR;
         sd_wr_req    <= 1'b0;
         sd_rd_req    <= 1'b0;
         sd_addr      <= '0;
         busy         <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_wr_elig && (!w_rd_elig || r_last_grant == GRANT_RD)) begin
                  r_state   <= ST_WR_REQ;
                  sd_wr_req <= 1'b1;
                  sd_addr   <= {wr_bank, w_wr_start};
                  busy      <= 1'b1;
                  if (w_rd_elig) r_last_grant <= GRANT_WR;
               end else if (w_rd_elig) begin
                  r_state   <= ST_RD_REQ;
                  sd_rd_req <= 1'b1;
                  sd_addr   <= {rd_bank, w_rd_start};
                  busy      <= 1'b1;
                  if (w_wr_elig) r_last_grant <= GRANT_RD;
               end
            end
            ST_WR_REQ: begin
               if (sd_ack) begin
                  sd_wr_req <= 1'b0;
                  if (sd_done) begin
                     r_state <= ST_IDLE;
                     busy    <= 1'b0;
                  end else begin
                     r_state <= ST_WR_BURST;
                  end
               end
            end
            ST_WR_BURST: begin
               if (sd_done) begin
                  r_state <= ST_IDLE;
                  busy    <= 1'b0;
               end
            end
            ST_RD_REQ: begin
               if (sd_ack) begin
                  sd_rd_req <= 1'b0;
                  if (sd_done) begin
                     r_state <= ST_IDLE;
                     busy    <= 1'b0;
                  end else begin
                     r_state <= ST_RD_BURST;
                  end
               end
            end
            ST_RD_BURST: begin
               if (sd_done) begin
                  r_state <= ST_IDLE;
                  busy    <= 1'b0;
               end
            end
            default: begin
               r_state   <= ST_IDLE;
               sd_wr_req <= 1'b0;
               sd_rd_req <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

   frame_addr_ctr #(
      .ADDR_W      (ADDR_W),
      .BURST_LEN   (BURST_LEN),
      .FRAME_WORDS (FRAME_WORDS)
   ) u_wr_ctr (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (wr_load),
      .step       (w_wr_step),
      .busy_own   (w_wr_own),
      .addr       (w_wr_addr),
      .frame_done (frame_write_done)
   );

   frame_addr_ctr #(
      .ADDR_W      (ADDR_W),
      .BURST_LEN   (BURST_LEN),
      .FRAME_WORDS (FRAME_WORDS)
   ) u_rd_ctr (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (rd_load),
      .step       (w_rd_step),
      .busy_own   (w_rd_own),
      .addr       (w_rd_addr),
      .frame_done (frame_read_done)
   );

endmodule
`default_nettype wire

// File: tb/tb_sdram_burst_scheduler.sv
`default_nettype none
// ============================================================================
// tb_sdram_burst_scheduler : randomized bench against a transaction-level scheduler model
// Revision: 1.0
// ============================================================================
module tb_sdram_burst_scheduler;

   localparam int ADDR_W      = 20;
   localparam int FIFO_W      = 10;
   localparam int BURST_LEN   = 256;
   localparam int FRAME_WORDS = 307200;
   localparam int RD_THRESH   = 512;

   localparam int OWN_NONE = 0;
   localparam int OWN_WR   = 1;
   localparam int OWN_RD   = 2;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              wr_load = 1'b0;
   logic              rd_load = 1'b0;
   logic [1:0]        wr_bank = 2'd0;
   logic [1:0]        rd_bank = 2'd0;
   logic [FIFO_W-1:0] wrf_usedw = '0;
   logic [FIFO_W-1:0] rdf_usedw = '0;
   logic              rd_enable = 1'b0;
   logic              sd_ack = 1'b0;
   logic              sd_done = 1'b0;
   logic              sd_wr_req;
   logic              sd_rd_req;
   logic [ADDR_W+1:0] sd_addr;
   logic              frame_write_done;
   logic              frame_read_done;
   logic              busy;

   always #5 clk = ~clk;

   sdram_burst_scheduler #(
      .ADDR_W      (ADDR_W),
      .FIFO_W      (FIFO_W),
      .BURST_LEN   (BURST_LEN),
      .FRAME_WORDS (FRAME_WORDS),
      .RD_THRESH   (RD_THRESH)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .wr_load          (wr_load),
      .rd_load          (rd_load),
      .wr_bank          (wr_bank),
      .rd_bank          (rd_bank),
      .wrf_usedw        (wrf_usedw),
      .rdf_usedw        (rdf_usedw),
      .rd_enable        (rd_enable),
      .sd_ack           (sd_ack),
      .sd_done          (sd_done),
      .sd_wr_req        (sd_wr_req),
      .sd_rd_req        (sd_rd_req),
      .sd_addr          (sd_addr),
      .frame_write_done (frame_write_done),
      .frame_read_done  (frame_read_done),
      .busy             (busy)
   );

   int n_vectors     = 0;
   int n_miscompares = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vectors++;
      if (got !== exp) begin
         n_miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Transaction-level view: who holds the bus, whether the controller took it, and per-path frame state.
   int     m_owner;
   bit     m_accepted;
   bit     m_prefer_rd;
   int     m_addr  [2];
   bit     m_fdone [2];
   bit     m_pend  [2];
   longint m_sd_addr;

   task automatic model_reset();
      m_owner     = OWN_NONE;
      m_accepted  = 1'b0;
      m_prefer_rd = 1'b1;
      m_sd_addr   = 0;
      for (int p = 0; p < 2; p++) begin
         m_addr[p]  = 0;
         m_fdone[p] = 1'b0;
         m_pend[p]  = 1'b0;
      end
   endtask

   task automatic model_edge();
      bit ld [2];
      bit stp [2];
      bit own [2];
      bit elig [2];
      int g;
      ld[0]   = wr_load;
      ld[1]   = rd_load;
      elig[0] = (int'(wrf_usedw) >= BURST_LEN) && !m_fdone[0];
      elig[1] = rd_enable && (int'(rdf_usedw) < RD_THRESH) && !m_fdone[1];
      for (int p = 0; p < 2; p++) begin
         own[p] = (m_owner == p + 1);
         stp[p] = own[p] && sd_done && (m_accepted || sd_ack);
      end
      if (m_owner == OWN_NONE) begin
         g = OWN_NONE;
         if (elig[0] && elig[1]) begin
            g = m_prefer_rd ? OWN_RD : OWN_WR;
            m_prefer_rd = !m_prefer_rd;
         end else if (elig[0]) begin
            g = OWN_WR;
         end else if (elig[1]) begin
            g = OWN_RD;
         end
         if (g != OWN_NONE) begin
            m_owner    = g;
            m_accepted = 1'b0;
            m_sd_addr  = longint'(g == OWN_WR ? int'(wr_bank) : int'(rd_bank)) * (longint'(1) << ADDR_W)
                         + longint'(ld[g-1] ? 0 : m_addr[g-1]);
         end
      end else if (stp[m_owner-1]) begin
         m_owner    = OWN_NONE;
         m_accepted = 1'b0;
      end else if (sd_ack) begin
         m_accepted = 1'b1;
      end
      for (int p = 0; p < 2; p++) begin
         if (ld[p]) begin
            if (!own[p] || stp[p]) begin
               m_addr[p] = 0; m_fdone[p] = 1'b0; m_pend[p] = 1'b0;
            end else begin
               m_pend[p] = 1'b1;
            end
         end else if (stp[p]) begin
            if (m_pend[p]) begin
               m_addr[p] = 0; m_fdone[p] = 1'b0; m_pend[p] = 1'b0;
            end else begin
               m_addr[p] = m_addr[p] + BURST_LEN;
               if (m_addr[p] == FRAME_WORDS) begin
                  m_addr[p]  = 0;
                  m_fdone[p] = 1'b1;
               end
            end
         end
      end
   endtask

   task automatic compare_outputs();
      check("sd_wr_req", 32'(sd_wr_req), 32'(m_owner == OWN_WR && !m_accepted));
      check("sd_rd_req", 32'(sd_rd_req), 32'(m_owner == OWN_RD && !m_accepted));
      check("busy", 32'(busy), 32'(m_owner != OWN_NONE));
      check("frame_write_done", 32'(frame_write_done), 32'(m_fdone[0]));
      check("frame_read_done", 32'(frame_read_done), 32'(m_fdone[1]));
      if (m_owner != OWN_NONE) check("sd_addr", 32'(sd_addr), 32'(m_sd_addr));
   endtask

   // mode 0: random traffic; 1: write stream only; 2: read stream only
   task automatic drive(input int mode, input bit force_wl, input bit force_rl);
      int ack_pct;
      int done_pct;
      ack_pct  = (mode == 0) ? 35 : 80;
      done_pct = (mode == 0) ? 30 : 80;
      sd_ack   = 1'b0;
      sd_done  = 1'b0;
      if (m_owner != OWN_NONE) begin
         if (!m_accepted) begin
            if ($urandom_range(99) < ack_pct) begin
               sd_ack  = 1'b1;
               sd_done = ($urandom_range(99) < 20);
            end
         end else begin
            sd_done = ($urandom_range(99) < done_pct);
         end
      end
      if ($urandom_range(7) == 0) wr_bank = 2'($urandom_range(3));
      if ($urandom_range(7) == 0) rd_bank = 2'($urandom_range(3));
      wr_load = 1'b0;
      rd_load = 1'b0;
      if (mode == 0) begin
         wr_load   = ($urandom_range(29) == 0);
         rd_load   = ($urandom_range(29) == 0);
         rd_enable = ($urandom_range(3) != 0);
         wrf_usedw = 10'($urandom_range(1023));
         rdf_usedw = 10'($urandom_range(1023));
         if ($urandom_range(3) == 0) wrf_usedw = 10'(BURST_LEN - 1 + $urandom_range(1));
         if ($urandom_range(3) == 0) rdf_usedw = 10'(RD_THRESH - 1 + $urandom_range(1));
      end else if (mode == 1) begin
         rd_enable = 1'b0;
         wrf_usedw = 10'($urandom_range(1023, BURST_LEN));
         rdf_usedw = 10'($urandom_range(1023));
      end else begin
         rd_enable = 1'b1;
         wrf_usedw = 10'($urandom_range(BURST_LEN - 1));
         rdf_usedw = 10'($urandom_range(RD_THRESH - 1));
      end
      wr_load = wr_load | force_wl;
      rd_load = rd_load | force_rl;
   endtask

   task automatic cycle(input int mode, input bit force_wl, input bit force_rl);
      @(negedge clk);
      compare_outputs();
      drive(mode, force_wl, force_rl);
      @(posedge clk);
      model_edge();
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, ".sd_wr_req"}, 32'(sd_wr_req), 32'd0);
      check({tag, ".sd_rd_req"}, 32'(sd_rd_req), 32'd0);
      check({tag, ".sd_addr"}, 32'(sd_addr), 32'd0);
      check({tag, ".frame_write_done"}, 32'(frame_write_done), 32'd0);
      check({tag, ".frame_read_done"}, 32'(frame_read_done), 32'd0);
      check({tag, ".busy"}, 32'(busy), 32'd0);
   endtask

   initial begin
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_all_zero("reset");
      rst_n = 1'b1;
      @(posedge clk);
      model_edge();

      // Write-only start, then mixed random traffic.
      cycle(1, 1'b1, 1'b0);
      repeat (40) cycle(1, 1'b0, 1'b0);
      repeat (3000) cycle(0, 1'b0, 1'b0);

      // Run one full write frame without loads.
      cycle(1, 1'b1, 1'b0);
      for (int i = 0; i < 12000 && !m_fdone[0]; i++) cycle(1, 1'b0, 1'b0);
      repeat (40) cycle(1, 1'b0, 1'b0);
      #1;
      check("frame_write_done_reached", 32'(frame_write_done), 32'd1);
      cycle(1, 1'b1, 1'b0);
      repeat (60) cycle(1, 1'b0, 1'b0);

      // Read stream, then asynchronous reset in the middle of a read burst.
      cycle(2, 1'b0, 1'b1);
      repeat (200) cycle(2, 1'b0, 1'b0);
      for (int i = 0; i < 400 && !(m_owner == OWN_RD && m_accepted); i++) cycle(2, 1'b0, 1'b0);
      check("rd_burst_reached", 32'(m_owner == OWN_RD && m_accepted), 32'd1);
      #2;
      rst_n   = 1'b0;
      sd_ack  = 1'b0;
      sd_done = 1'b0;
      wr_load = 1'b0;
      rd_load = 1'b0;
      #1;
      check_all_zero("async_reset");
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      model_edge();

      repeat (3000) cycle(0, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/sdram_burst_scheduler.md
Name: sdram_burst_scheduler

Overview:
Schedules SDRAM burst accesses between the camera write path and the VGA read path of the frame-buffer pipeline. It watches write-FIFO and read-FIFO fill levels, grants one burst at a time to the SDRAM controller, and generates per-frame burst addresses inside the banks selected by the bank-switch logic. It produces the frame_write_done/frame_read_done levels that the bank switcher waits on before toggling banks.

Parameters:
ADDR_W, 20, word-address width within one bank
FIFO_W, 10, width of FIFO used-word counts
BURST_LEN, 256, words per burst; must be a power of 2 and at most 2**FIFO_W
FRAME_WORDS, 307200, words per frame (640x480); must be a multiple of BURST_LEN
RD_THRESH, 512, read burst is eligible when rdf_usedw is below this value

Ports:
clk  in  1  system clock; all logic on the rising edge
rst_n  in  1  asynchronous active-low reset
wr_load  in  1  one-cycle pulse: restart write frame address at 0
rd_load  in  1  one-cycle pulse: restart read frame address at 0
wr_bank  in  2  SDRAM bank for writes
rd_bank  in  2  SDRAM bank for reads
wrf_usedw  in  FIFO_W  write-FIFO (camera to SDRAM) fill count
rdf_usedw  in  FIFO_W  read-FIFO (SDRAM to VGA) fill count
rd_enable  in  1  display path active; reads are allowed only when this is high
sd_ack  in  1  one-cycle pulse: controller accepted the request
sd_done  in  1  one-cycle pulse: burst complete
sd_wr_req  out  1  write-burst request
sd_rd_req  out  1  read-burst request
sd_addr  out  ADDR_W+2  {bank[1:0], word address} of the burst
frame_write_done  out  1  level: the whole write frame has been transferred
frame_read_done  out  1  level: the whole read frame has been transferred
busy  out  1  a burst is requested or in progress

Behaviour:
- Reset values: all outputs 0; wr_addr and rd_addr 0; FSM in IDLE; last_grant set to WRITE, so the first tie goes to read.
- Eligibility:
  - wr_elig = (wrf_usedw >= BURST_LEN) && !frame_write_done.
  - rd_elig = rd_enable && (rdf_usedw < RD_THRESH) && !frame_read_done.
- FSM states: IDLE, WR_REQ, WR_BURST, RD_REQ, RD_BURST.
  - IDLE: if only one path is eligible, go to its REQ state.
  - IDLE: if both are eligible, grant the path opposite to last_grant (round robin) and update last_grant.
  - IDLE: if neither is eligible, stay.
  - Eligibility is sampled in IDLE only; the request is registered and asserts the cycle after the decision.
- REQ states: hold the request high and sd_addr stable until sd_ack.
  - On sd_ack, drop the request next cycle and go to the BURST state.
  - If sd_ack and sd_done arrive in the same cycle, go directly to IDLE and apply the done actions.
- BURST states: hold sd_addr until sd_done.
  - On sd_done, add BURST_LEN to the path's address and return to IDLE.
  - If the new address equals FRAME_WORDS, set that path's frame_done and wrap its address to 0.
- Minimum gap between bursts: 1 IDLE cycle.
- sd_addr: bank and address are latched when entering the REQ state. A wr_bank/rd_bank change mid-burst has no effect on the burst in flight.
- Load handling:
  - wr_load in any state other than WR_REQ/WR_BURST: next cycle wr_addr is 0 and frame_write_done is 0.
  - wr_load during WR_REQ/WR_BURST: set a pending flag. On the burst's sd_done, clear wr_addr and frame_write_done instead of incrementing; the burst itself completes normally.
  - rd_load follows the same rules symmetrically.
  - Load and sd_done in the same cycle for the same path: the load wins and the address becomes 0.
- frame_*_done stays high until the matching load. It blocks further bursts on that path, so the bank switcher's wait on frame_*_done always completes.
- busy = (state != IDLE).
- Reset mid-burst: everything returns to reset values immediately. The SDRAM controller must be reset by the same rst_n.
- Width rules: address arithmetic is unsigned ADDR_W bits. FRAME_WORDS must be below 2**ADDR_W; elaboration fails on a parameter violation.

Decomposition:
- Shared package: FSM state encoding, grant enum {GRANT_WR, GRANT_RD}, and an elaboration-time parameter-check function.
- One natural sub-module, frame_addr_ctr, instantiated twice (write and read). Its ports are clk, rst_n, load, step, busy_own; outputs are addr and frame_done. It contains the pending-load logic.

Test Plan:
- Write only: rd_enable=0, wrf_usedw=300, wr_load pulse -> sd_wr_req high 2 cycles after the load. sd_addr={wr_bank,0}; after ack+done the next request has address 256.
- Round robin: wrf_usedw=300, rdf_usedw=0, rd_enable=1 -> grant order is RD, WR, RD, WR. Read addresses are 0, 256; write addresses are 0, 256.
- Frame end: run 1200 write bursts -> frame_write_done rises the cycle after the 1200th sd_done and no further sd_wr_req issues. A wr_load then clears the flag and the next address is 0.
- Load mid-burst: wr_load while in WR_BURST at address 1024 -> the burst finishes and the next write request carries address 0.
- Bank change mid-burst: toggle rd_bank between sd_ack and sd_done -> sd_addr bank bits unchanged until done; the next read request uses the new bank.
- Same-cycle ack+done and async reset: with sd_ack=sd_done=1 in one cycle, the FSM goes to IDLE and the address advances by 256. Asserting rst_n=0 in RD_BURST drives all outputs to 0 with no clock edge.
